// File: rtl/sram_1rw_banked_ext.sv
// rtl/sram_1rw_banked_ext.sv - single-port byte-masked banked SRAM with init sweep and registered read port
//
// Purpose:
//   Parametrised 1RW SRAM array split into 2^BANK_BITS banks with per-lane write masking.
//   After reset an initialisation sequencer writes zero to every row of every bank.
//   The array accepts requests only after that sweep completes.
//   Read data is registered and held until the next accepted read, with a one-cycle valid strobe.
//
// Ports:
//   RW0_clk     in   1           clock, all state on rising edge
//   RW0_rst_n   in   1           asynchronous active-low reset
//   RW0_addr    in   ADDR_WIDTH  word address, top BANK_BITS select the bank, low bits the row
//   RW0_en      in   1           request strobe
//   RW0_wmode   in   1           1 = write, 0 = read
//   RW0_wmask   in   MASK_WIDTH  per-lane write enable
//   RW0_wdata   in   DATA_WIDTH  write data
//   RW0_rdata   out  DATA_WIDTH  registered read data, held between reads
//   RW0_rvalid  out  1           one-cycle pulse when rdata was loaded
//   RW0_ready   out  1           initialisation done, requests accepted
//   RW0_csb     out  BANKS       active-low one-hot bank select (combinational)

module sram_1rw_banked_ext #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 256,
   parameter int MASK_WIDTH = 32,
   parameter int BANK_BITS  = 2
) (
   input  logic                        RW0_clk,
   input  logic                        RW0_rst_n,
   input  logic [ADDR_WIDTH-1:0]       RW0_addr,
   input  logic                        RW0_en,
   input  logic                        RW0_wmode,
   input  logic [MASK_WIDTH-1:0]       RW0_wmask,
   input  logic [DATA_WIDTH-1:0]       RW0_wdata,
   output logic [DATA_WIDTH-1:0]       RW0_rdata,
   output logic                        RW0_rvalid,
   output logic                        RW0_ready,
   output logic [(2**BANK_BITS)-1:0]   RW0_csb
);

   localparam int BANKS    = 2**BANK_BITS;
   localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
   localparam int ROWS     = 2**ROW_BITS;
   localparam int LANE_W   = DATA_WIDTH / MASK_WIDTH;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   logic [0:0]            state_q, state_d;
   logic [ROW_BITS-1:0]   row_cnt_q, row_cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic [BANK_BITS-1:0]  bank_sel;
   logic [ROW_BITS-1:0]   row_sel;
   logic                  run;
   logic                  req_ok;
   logic                  rd_fire;

   assign bank_sel = RW0_addr[ADDR_WIDTH-1 -: BANK_BITS];
   assign row_sel  = RW0_addr[ROW_BITS-1:0];
   assign run      = (state_q == ST_RUN);
   assign req_ok   = RW0_en & run;
   assign rd_fire  = req_ok & ~RW0_wmode;

   // ------------------------------------------------------------------
   // Shared write port: the init sweep and run-time writes never overlap,
   // so one row/data/lane bus feeds every bank.
   // ------------------------------------------------------------------
   logic [ROW_BITS-1:0]   wr_row;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [MASK_WIDTH-1:0] lane_we;
   logic                  init_we;
   logic [BANKS-1:0]      bank_we;
   logic [DATA_WIDTH-1:0] bank_rdata [BANKS];

   // The sweep writes only on edges where reset is released, so holding
   // reset low never touches the array.
   assign init_we = (state_q == ST_INIT) & RW0_rst_n;

   always_comb begin
      wr_row  = row_sel;
      wr_data = RW0_wdata;
      lane_we = RW0_wmask;
      if (state_q == ST_INIT) begin
         wr_row  = row_cnt_q;
         wr_data = '0;
         lane_we = '1;
      end
   end

   // ------------------------------------------------------------------
   // Banks
   // ------------------------------------------------------------------
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem_q [ROWS];

      assign RW0_csb[b]    = ~(req_ok & (bank_sel == BANK_BITS'(b)));
      assign bank_we[b]    = init_we | (~RW0_csb[b] & RW0_wmode);
      assign bank_rdata[b] = mem_q[row_sel];

      // Storage is deliberately not reset; its contents come from the sweep.
      always_ff @(posedge RW0_clk) begin
         if (bank_we[b]) begin
            for (int l = 0; l < MASK_WIDTH; l++) begin
               if (lane_we[l]) begin
                  mem_q[wr_row][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      if (state_q == ST_INIT) begin
         row_cnt_d = row_cnt_q + ROW_BITS'(1);
         // The edge writing the last row hands over to RUN; the counter
         // wraps to zero but is never used again until the next reset.
         if (&row_cnt_q) begin
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_fire;
      if (rd_fire) begin
         rdata_d = bank_rdata[bank_sel];
      end
   end

   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         state_q   <= ST_INIT;
         row_cnt_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign RW0_rdata  = rdata_q;
   assign RW0_rvalid = rvalid_q;
   assign RW0_ready  = run;

endmodule

// File: tb/tb_sram_1rw_banked_ext.sv
// tb/tb_sram_1rw_banked_ext.sv - directed table-driven bench for sram_1rw_banked_ext

module tb_sram_1rw_banked_ext;

   logic         clk;
   logic         rst_n;
   logic [8:0]   addr;
   logic         en;
   logic         wmode;
   logic [31:0]  wmask;
   logic [255:0] wdata;
   logic [255:0] rdata;
   logic         rvalid;
   logic         ready;
   logic [3:0]   csb;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         en;
      logic         wm;
      logic [8:0]   addr;
      logic [31:0]  mask;
      logic [255:0] wdata;
      logic [3:0]   csb;
      logic         rvalid;
      logic [255:0] rdata;
   } vec_t;

   vec_t vt[$];

   localparam logic [255:0] ZERO   = '0;
   localparam logic [255:0] ONES   = '1;
   localparam logic [255:0] MASKED = {{28{8'hFF}}, 32'h0};
   localparam logic [255:0] PA5    = {32{8'hA5}};
   localparam logic [255:0] P5A    = {32{8'h5A}};
   localparam logic [255:0] P3C    = {32{8'h3C}};
   localparam logic [255:0] PC3    = {32{8'hC3}};
   localparam logic [255:0] P1     = {8{32'h0101_1010}};
   localparam logic [255:0] P2     = {8{32'h2202_2020}};
   localparam logic [255:0] P3     = {8{32'h3303_3030}};
   localparam logic [255:0] PDEAD  = {16{16'hDEAD}};
   localparam logic [255:0] P1234  = {16{16'h1234}};
   localparam logic [255:0] TOPLN  = {8'hFF, 248'h0};

   sram_1rw_banked_ext #(
      .ADDR_WIDTH(9), .DATA_WIDTH(256), .MASK_WIDTH(32), .BANK_BITS(2)
   ) dut (
      .RW0_clk   (clk),
      .RW0_rst_n (rst_n),
      .RW0_addr  (addr),
      .RW0_en    (en),
      .RW0_wmode (wmode),
      .RW0_wmask (wmask),
      .RW0_wdata (wdata),
      .RW0_rdata (rdata),
      .RW0_rvalid(rvalid),
      .RW0_ready (ready),
      .RW0_csb   (csb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic w, input logic [8:0] a,
                               input logic [31:0] m, input logic [255:0] d,
                               input logic [3:0] cs, input logic rv, input logic [255:0] rd);
      vec_t v;
      v.en = e; v.wm = w; v.addr = a; v.mask = m; v.wdata = d;
      v.csb = cs; v.rvalid = rv; v.rdata = rd;
      return v;
   endfunction

   // Called just after a rising edge: drive, check csb, clock, check outputs.
   task automatic apply(input vec_t v, input string tag);
      en = v.en; wmode = v.wm; addr = v.addr; wmask = v.mask; wdata = v.wdata;
      #1;
      chk({tag, " csb"}, {252'h0, csb}, {252'h0, v.csb});
      @(posedge clk);
      #1;
      chk({tag, " rvalid"}, {255'h0, rvalid}, {255'h0, v.rvalid});
      chk({tag, " rdata"}, rdata, v.rdata);
   endtask

   // Counts n init edges; ready must be low except at edge n when expect_done.
   // With poke set, requests to 0x003 are driven that must all be ignored.
   task automatic sweep(input int n, input bit poke, input bit expect_done);
      for (int i = 1; i <= n; i++) begin
         en = 1'b0; wmode = 1'b0; addr = 9'h003; wmask = '1; wdata = PDEAD;
         if (poke && i == 10) begin
            en = 1'b1; wmode = 1'b1;
         end else if (poke && i > 10 && i <= 20) begin
            en = 1'b1;
         end
         #1;
         chk($sformatf("init csb e%0d", i), {252'h0, csb}, {252'h0, 4'hF});
         @(posedge clk);
         #1;
         chk($sformatf("init ready e%0d", i), {255'h0, ready},
             {255'h0, (expect_done && i == n)});
         chk($sformatf("init rvalid e%0d", i), {255'h0, rvalid}, ZERO);
      end
      en = 1'b0;
   endtask

   // Called just after a rising edge: 1-unit reset pulse well before the next edge.
   task automatic rst_pulse(input string tag);
      en = 1'b1; wmode = 1'b0; addr = 9'h020;
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, " ready"}, {255'h0, ready}, ZERO);
      chk({tag, " rvalid"}, {255'h0, rvalid}, ZERO);
      chk({tag, " rdata"}, rdata, ZERO);
      chk({tag, " csb"}, {252'h0, csb}, {252'h0, 4'hF});
      rst_n = 1'b1;
      en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;

      // Main vector table for the RUN phase.
      vt.push_back(mk(1, 0, 9'h003, 32'h0, ZERO, 4'hE, 1, ZERO));
      vt.push_back(mk(1, 0, 9'h000, 32'h0, ZERO, 4'hE, 1, ZERO));
      vt.push_back(mk(1, 0, 9'h07F, 32'h0, ZERO, 4'hE, 1, ZERO));
      vt.push_back(mk(1, 0, 9'h180, 32'h0, ZERO, 4'h7, 1, ZERO));
      vt.push_back(mk(1, 0, 9'h1FF, 32'h0, ZERO, 4'h7, 1, ZERO));
      vt.push_back(mk(0, 0, 9'h000, 32'h0, ZERO, 4'hF, 0, ZERO));
      vt.push_back(mk(1, 1, 9'h085, 32'hFFFF_FFFF, ONES, 4'hD, 0, ZERO));
      vt.push_back(mk(1, 1, 9'h085, 32'h0000_000F, ZERO, 4'hD, 0, ZERO));
      vt.push_back(mk(1, 0, 9'h085, 32'h0, ZERO, 4'hD, 1, MASKED));
      vt.push_back(mk(1, 1, 9'h005, 32'hFFFF_FFFF, PA5, 4'hE, 0, MASKED));
      vt.push_back(mk(1, 1, 9'h085, 32'hFFFF_FFFF, P5A, 4'hD, 0, MASKED));
      vt.push_back(mk(1, 1, 9'h105, 32'hFFFF_FFFF, P3C, 4'hB, 0, MASKED));
      vt.push_back(mk(1, 1, 9'h185, 32'hFFFF_FFFF, PC3, 4'h7, 0, MASKED));
      vt.push_back(mk(1, 0, 9'h005, 32'h0, ZERO, 4'hE, 1, PA5));
      vt.push_back(mk(1, 0, 9'h085, 32'h0, ZERO, 4'hD, 1, P5A));
      vt.push_back(mk(1, 0, 9'h105, 32'h0, ZERO, 4'hB, 1, P3C));
      vt.push_back(mk(1, 0, 9'h185, 32'h0, ZERO, 4'h7, 1, PC3));
      vt.push_back(mk(1, 1, 9'h005, 32'h0, ZERO, 4'hE, 0, PC3));
      vt.push_back(mk(1, 0, 9'h005, 32'h0, ZERO, 4'hE, 1, PA5));
      vt.push_back(mk(1, 1, 9'h010, 32'hFFFF_FFFF, P1, 4'hE, 0, PA5));
      vt.push_back(mk(1, 1, 9'h011, 32'hFFFF_FFFF, P2, 4'hE, 0, PA5));
      vt.push_back(mk(1, 0, 9'h010, 32'h0, ZERO, 4'hE, 1, P1));
      vt.push_back(mk(1, 0, 9'h011, 32'h0, ZERO, 4'hE, 1, P2));
      vt.push_back(mk(0, 0, 9'h010, 32'h0, ZERO, 4'hF, 0, P2));
      vt.push_back(mk(0, 0, 9'h010, 32'h0, ZERO, 4'hF, 0, P2));
      vt.push_back(mk(0, 0, 9'h010, 32'h0, ZERO, 4'hF, 0, P2));
      vt.push_back(mk(1, 1, 9'h010, 32'hFFFF_FFFF, P3, 4'hE, 0, P2));
      vt.push_back(mk(0, 0, 9'h010, 32'h0, ZERO, 4'hF, 0, P2));
      vt.push_back(mk(1, 0, 9'h010, 32'h0, ZERO, 4'hE, 1, P3));
      vt.push_back(mk(1, 1, 9'h1FF, 32'h8000_0000, ONES, 4'h7, 0, P3));
      vt.push_back(mk(1, 0, 9'h1FF, 32'h0, ZERO, 4'h7, 1, TOPLN));

      // Reset values, with a request driven to prove csb stays deasserted.
      #2;
      en = 1'b1;
      #1;
      chk("reset ready", {255'h0, ready}, ZERO);
      chk("reset rvalid", {255'h0, rvalid}, ZERO);
      chk("reset rdata", rdata, ZERO);
      chk("reset csb", {252'h0, csb}, {252'h0, 4'hF});
      en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Init sweep with ignored requests to 0x003 from edge 10.
      sweep(128, 1'b1, 1'b1);

      for (int k = 0; k < vt.size(); k++) begin
         apply(vt[k], $sformatf("vec%0d", k));
      end

      // Reset in RUN, then again at init edge 50, then full sweep.
      apply(mk(1, 1, 9'h020, 32'hFFFF_FFFF, P1234, 4'hE, 0, TOPLN), "w020");
      apply(mk(1, 0, 9'h020, 32'h0, ZERO, 4'hE, 1, P1234), "r020");
      rst_pulse("rst run");
      sweep(50, 1'b0, 1'b0);
      rst_pulse("rst init");
      sweep(128, 1'b0, 1'b1);
      apply(mk(0, 0, 9'h020, 32'h0, ZERO, 4'hF, 0, ZERO), "post idle");
      apply(mk(1, 0, 9'h020, 32'h0, ZERO, 4'hE, 1, ZERO), "post r020");
      apply(mk(0, 0, 9'h020, 32'h0, ZERO, 4'hF, 0, ZERO), "post hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
